// File: rtl/mul_if.sv
// mul_if: request/response bundle for the pipelined multiplier.
interface mul_if #(
   parameter int unsigned W  = 32,
   parameter int unsigned TW = 5
) ();
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [1:0]    mulctl;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  mulres;
   logic [TW-1:0] out_tag;

   // Issuer / consumer side.
   modport master (
      output in_valid, a, b, mulctl, in_tag, out_ready,
      input  in_ready, out_valid, mulres, out_tag
   );

   // Multiplier side.
   modport slave (
      input  in_valid, a, b, mulctl, in_tag, out_ready,
      output in_ready, out_valid, mulres, out_tag
   );
endinterface

// File: rtl/mul_pipe.sv
// mul_pipe: fully pipelined RV32M/RV64M multiply unit with valid/ready handshake,
// tag passthrough, bubble-collapsing back-pressure and a whole-pipe flush.
// The product is formed ahead of stage 0; the following stages only carry the
// result, so retiming is free to spread the multiplier across the pipe.
module mul_pipe #(
   parameter int unsigned W  = 32,
   parameter int unsigned L  = 4,
   parameter int unsigned TW = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   mul_if.slave bus
);
   localparam int unsigned PW = 2 * W;

   logic [L-1:0]         v;
   logic [W-1:0]         res [L];
   logic [TW-1:0]        tag [L];
   logic [L-1:0]         move;    // stage k hands its entry forward this cycle
   logic [L-1:0]         free;    // stage k can take a new entry this cycle
   logic                 accept;
   logic signed [W:0]    ea;
   logic signed [W:0]    eb;
   logic signed [PW-1:0] prod;
   logic [W-1:0]         res_in;

   // Operand extension per mulctl, full-width product and half select.
   always_comb begin
      ea     = {(bus.mulctl != 2'b11) & bus.a[W-1], bus.a};
      eb     = {~bus.mulctl[1] & bus.b[W-1], bus.b};
      prod   = PW'(ea) * PW'(eb);
      res_in = (bus.mulctl == 2'b00) ? prod[W-1:0] : prod[PW-1:W];
   end

   // Advance chain from the output backwards; an empty stage anywhere ahead lets earlier stages move.
   always_comb begin
      move      = '0;
      free      = '0;
      move[L-1] = v[L-1] & bus.out_ready;
      free[L-1] = ~v[L-1] | bus.out_ready;
      for (int k = int'(L) - 2; k >= 0; k--) begin
         move[k] = v[k] & free[k+1];
         free[k] = ~v[k] | move[k];
      end
   end

   assign accept = bus.in_valid & free[0];

   // Stage valid bits and payload; payload only changes when a stage loads, so stalls hold it.
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
         for (int k = 0; k < int'(L); k++) begin
            res[k] <= '0;
            tag[k] <= '0;
         end
      end else begin
         if (flush) begin
            v <= '0;
         end else begin
            v[0] <= accept | (v[0] & ~move[0]);
            for (int k = 1; k < int'(L); k++) begin
               v[k] <= move[k-1] | (v[k] & ~move[k]);
            end
         end
         if (accept) begin
            res[0] <= res_in;
            tag[0] <= bus.in_tag;
         end
         for (int k = 1; k < int'(L); k++) begin
            if (move[k-1]) begin
               res[k] <= res[k-1];
               tag[k] <= tag[k-1];
            end
         end
      end
   end

   assign bus.in_ready  = free[0];
   assign bus.out_valid = v[L-1];
   assign bus.mulres    = res[L-1];
   assign bus.out_tag   = tag[L-1];
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: randomized and directed checks of mul_pipe against an in-order
// queue model whose results come from plain 64-bit arithmetic.
module tb_mul_pipe;
   localparam int unsigned W  = 32;
   localparam int unsigned L  = 4;
   localparam int unsigned TW = 5;

   typedef struct packed {
      logic [W-1:0]  res;
      logic [TW-1:0] tag;
   } ent_t;

   localparam logic [W-1:0] OP_A [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   localparam logic [W-1:0] OP_B [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   localparam logic [W-1:0] OP_R [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

   logic clk = 1'b0;
   logic rst;
   logic flush;

   mul_if #(.W(W), .TW(TW)) bus ();

   mul_pipe #(.W(W), .L(L), .TW(TW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp;
   int n_err;
   int cyc;
   ent_t pipe_q [$];   // model: accepted, not yet delivered
   ent_t exp_q  [$];   // model: expected delivery order
   ent_t got_q  [$];   // observed deliveries
   int   got_cyc[$];
   int   acc_cyc[$];

   int          s_cyc;
   int          s_cnt;
   logic        s_in_ready;
   logic        s_out_valid;
   logic        s_out_rdy;
   logic [W-1:0]  s_res;
   logic [TW-1:0] s_tag;
   logic        s_in_fire;
   logic        s_out_fire;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Architectural result from the RV32M rules using plain 64-bit signed arithmetic.
   function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] ctl);
      longint sa;
      longint sb;
      longint p;
      sa = (ctl == 2'b11) ? longint'({32'h0, a}) : longint'($signed(a));
      sb = ctl[1] ? longint'({32'h0, b}) : longint'($signed(b));
      p  = sa * sb;
      return (ctl == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return W'(1);
         2:       return '1;
         3:       return {1'b1, {(W-1){1'b0}}};
         4:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   task automatic set_in(input logic vld, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] ctl, input logic [TW-1:0] tag);
      bus.in_valid = vld;
      bus.a        = a;
      bus.b        = b;
      bus.mulctl   = ctl;
      bus.in_tag   = tag;
   endtask

   task automatic set_op(input logic vld, input logic [TW-1:0] tag);
      set_in(vld, pick(), pick(), 2'($urandom_range(0, 3)), tag);
   endtask

   task automatic clear_logs();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
      acc_cyc.delete();
   endtask

   // Sample mid-cycle, update the model with this cycle's transfers, then pass the edge.
   task automatic step();
      ent_t e;
      @(negedge clk);
      s_cyc       = cyc;
      s_in_ready  = bus.in_ready;
      s_out_valid = bus.out_valid;
      s_out_rdy   = bus.out_ready;
      s_res       = bus.mulres;
      s_tag       = bus.out_tag;
      s_cnt       = pipe_q.size();
      s_in_fire   = bus.in_valid && s_in_ready && !flush && !rst;
      s_out_fire  = s_out_valid && s_out_rdy;
      if (s_out_fire) begin
         got_q.push_back({s_res, s_tag});
         got_cyc.push_back(s_cyc);
         e = 'x;
         if (pipe_q.size() > 0) e = pipe_q.pop_front();
         exp_q.push_back(e);
      end
      if (rst || flush) begin
         pipe_q.delete();
      end else if (s_in_fire) begin
         pipe_q.push_back({ref_mul(bus.a, bus.b, bus.mulctl), bus.in_tag});
         acc_cyc.push_back(s_cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      flush = 1'b0;
      bus.out_ready = 1'b0;
      set_in(1'b0, '0, '0, 2'b00, '0);
      step();
      step();
      n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", s_out_valid); end
      n_cmp++; if (s_res !== '0) begin n_err++; $display("FAIL reset_mulres got %h exp 0", s_res); end
      n_cmp++; if (s_tag !== '0) begin n_err++; $display("FAIL reset_out_tag got %0d exp 0", s_tag); end
      rst = 1'b0;
      step();
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", s_in_ready); end
      clear_logs();
   endtask

   task automatic test_ops();
      int ca;
      bit found;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, OP_A[k], OP_B[k], 2'(k), TW'(k + 1));
         step();
         ca = s_cyc;
         set_in(1'b0, '0, '0, 2'b00, '0);
         found = 1'b0;
         for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (s_out_valid === 1'b1) found = 1'b1;
         end
         n_cmp++;
         if (!found || (s_cyc - ca) != int'(L)) begin
            n_err++; $display("FAIL ops_latency[%0d] got %0d exp %0d (found=%0b)", k, s_cyc - ca, L, found);
         end
         n_cmp++;
         if (s_res !== OP_R[k] || s_tag !== TW'(k + 1)) begin
            n_err++; $display("FAIL ops_result[%0d] got res=%h tag=%0d exp res=%h tag=%0d", k, s_res, s_tag, OP_R[k], k + 1);
         end
      end
      clear_logs();
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      clear_logs();
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, pick(), pick(), 2'(i), TW'(i));
         step();
      end
      set_in(1'b0, '0, '0, 2'b00, '0);
      for (int i = 0; i < 20 && got_q.size() < 8; i++) step();
      n_cmp++; if (acc_cyc.size() != 8 || got_q.size() != 8) begin
         n_err++; $display("FAIL b2b_count got acc=%0d out=%0d exp 8/8", acc_cyc.size(), got_q.size());
      end else begin
         n_cmp++; if (acc_cyc[7] - acc_cyc[0] != 7) begin n_err++; $display("FAIL b2b_accept_span got %0d exp 7", acc_cyc[7] - acc_cyc[0]); end
         n_cmp++; if (got_cyc[7] - got_cyc[0] != 7) begin n_err++; $display("FAIL b2b_output_span got %0d exp 7", got_cyc[7] - got_cyc[0]); end
         n_cmp++; if (got_cyc[0] - acc_cyc[0] != int'(L)) begin n_err++; $display("FAIL b2b_latency got %0d exp %0d", got_cyc[0] - acc_cyc[0], L); end
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got_q[i].tag !== TW'(i) || got_q[i] !== exp_q[i]) begin
               n_err++; $display("FAIL b2b_result[%0d] got res=%h tag=%0d exp res=%h tag=%0d", i, got_q[i].res, got_q[i].tag, exp_q[i].res, i);
            end
         end
      end
      clear_logs();
   endtask

   task automatic test_backpressure();
      int j;
      bus.out_ready = 1'b0;
      clear_logs();
      j = 0;
      set_op(1'b1, TW'(0));
      for (int c = 0; c < 8; c++) begin
         step();
         n_cmp++; if (s_in_ready !== ((s_cnt < int'(L)) || s_out_rdy)) begin
            n_err++; $display("FAIL bp_in_ready[%0d] got %b held %0d", c, s_in_ready, s_cnt);
         end
         if (s_out_valid === 1'b1 && pipe_q.size() > 0) begin
            n_cmp++; if ({s_res, s_tag} !== pipe_q[0]) begin
               n_err++; $display("FAIL bp_frozen[%0d] got res=%h tag=%0d exp res=%h tag=%0d", c, s_res, s_tag, pipe_q[0].res, pipe_q[0].tag);
            end
         end
         if (s_in_fire) begin j++; set_op(j < 6, TW'(j)); end
      end
      n_cmp++; if (j != int'(L)) begin n_err++; $display("FAIL bp_accepts got %0d exp %0d", j, L); end
      n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b exp 0", s_in_ready); end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 30 && (j < 6 || got_q.size() < 6); c++) begin
         step();
         if (s_in_fire) begin j++; set_op(j < 6, TW'(j)); end
      end
      n_cmp++; if (j != 6 || got_q.size() != 6) begin
         n_err++; $display("FAIL bp_drain_count got acc=%0d out=%0d exp 6/6", j, got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got_q[i].tag !== TW'(i) || got_q[i] !== exp_q[i]) begin
               n_err++; $display("FAIL bp_result[%0d] got res=%h tag=%0d exp res=%h tag=%0d", i, got_q[i].res, got_q[i].tag, exp_q[i].res, i);
            end
         end
      end
      clear_logs();
   endtask

   task automatic test_bubble();
      bus.out_ready = 1'b0;
      clear_logs();
      for (int c = 0; c < 8; c++) begin
         set_op(c % 2 == 0, TW'(c / 2));
         step();
         if (c % 2 == 0) begin
            n_cmp++; if (s_in_fire !== 1'b1) begin n_err++; $display("FAIL bubble_accept[%0d] got ready=%b exp 1", c / 2, s_in_ready); end
         end
      end
      set_in(1'b0, '0, '0, 2'b00, '0);
      step();
      n_cmp++; if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1) begin
         n_err++; $display("FAIL bubble_full got ready=%b valid=%b exp 0/1", s_in_ready, s_out_valid);
      end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 12 && got_q.size() < 4; c++) step();
      n_cmp++; if (got_q.size() != 4) begin
         n_err++; $display("FAIL bubble_drain_count got %0d exp 4", got_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_q[i].tag !== TW'(i) || got_q[i] !== exp_q[i]) begin
               n_err++; $display("FAIL bubble_result[%0d] got res=%h tag=%0d exp res=%h tag=%0d", i, got_q[i].res, got_q[i].tag, exp_q[i].res, i);
            end
         end
      end
      clear_logs();
   endtask

   task automatic test_flush();
      int seen;
      int ca;
      bit found;
      bus.out_ready = 1'b1;
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         set_op(1'b1, TW'(i + 1));
         step();
      end
      set_in(1'b0, '0, '0, 2'b00, '0);
      step();
      flush = 1'b1;
      set_op(1'b1, TW'(9));
      step();
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b exp 1", s_in_ready); end
      flush = 1'b0;
      set_in(1'b0, '0, '0, 2'b00, '0);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (s_out_valid !== 1'b0) seen++;
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_killed_valid got %0d cycles exp 0", seen); end
      n_cmp++; if (got_q.size() != 1) begin
         n_err++; $display("FAIL flush_out_count got %0d exp 1", got_q.size());
      end else begin
         n_cmp++; if (got_q[0].tag !== TW'(1) || got_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL flush_consumed got res=%h tag=%0d exp res=%h tag=1", got_q[0].res, got_q[0].tag, exp_q[0].res);
         end
      end
      set_op(1'b1, TW'(5));
      step();
      ca = s_cyc;
      set_in(1'b0, '0, '0, 2'b00, '0);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         step();
         if (s_out_valid === 1'b1) found = 1'b1;
      end
      n_cmp++; if (!found || (s_cyc - ca) != int'(L)) begin
         n_err++; $display("FAIL flush_next_latency got %0d exp %0d (found=%0b)", s_cyc - ca, L, found);
      end
      n_cmp++; if (exp_q.size() == 0 || s_tag !== TW'(5) || {s_res, s_tag} !== exp_q[exp_q.size() - 1]) begin
         n_err++; $display("FAIL flush_next_result got res=%h tag=%0d exp tag=5", s_res, s_tag);
      end
      clear_logs();
   endtask

   task automatic test_reset_mid();
      int seen;
      bus.out_ready = 1'b0;
      clear_logs();
      set_op(1'b1, TW'(0));
      for (int c = 0; c < 6; c++) begin
         step();
         if (s_in_fire) set_op(1'b1, TW'(c + 1));
      end
      rst = 1'b1;
      step();
      n_cmp++; if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0) begin
         n_err++; $display("FAIL rstmid_full got valid=%b ready=%b exp 1/0", s_out_valid, s_in_ready);
      end
      step();
      n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got %b exp 0", s_out_valid); end
      n_cmp++; if (s_res !== '0) begin n_err++; $display("FAIL rstmid_mulres got %h exp 0", s_res); end
      n_cmp++; if (s_tag !== '0) begin n_err++; $display("FAIL rstmid_out_tag got %0d exp 0", s_tag); end
      rst = 1'b0;
      set_in(1'b0, '0, '0, 2'b00, '0);
      step();
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b exp 1", s_in_ready); end
      bus.out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (s_out_valid !== 1'b0) seen++;
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstmid_ghost_valid got %0d cycles exp 0", seen); end
      clear_logs();
   endtask

   task automatic test_random();
      clear_logs();
      for (int c = 0; c < 400; c++) begin
         flush = ($urandom_range(0, 99) < 3);
         bus.out_ready = ($urandom_range(0, 99) < 60);
         set_op($urandom_range(0, 99) < 70, TW'($urandom));
         step();
         n_cmp++; if (s_in_ready !== ((s_cnt < int'(L)) || s_out_rdy)) begin
            n_err++; $display("FAIL rand_in_ready[%0d] got %b held %0d out_ready %b", c, s_in_ready, s_cnt, s_out_rdy);
         end
      end
      flush = 1'b0;
      bus.out_ready = 1'b1;
      set_in(1'b0, '0, '0, 2'b00, '0);
      for (int c = 0; c < 20 && pipe_q.size() > 0; c++) step();
      step();
      n_cmp++; if (pipe_q.size() != 0 || s_out_valid !== 1'b0) begin
         n_err++; $display("FAIL rand_drain got left=%0d valid=%b exp 0/0", pipe_q.size(), s_out_valid);
      end
      for (int i = 0; i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL rand_result[%0d] got res=%h tag=%0d exp res=%h tag=%0d", i, got_q[i].res, got_q[i].tag, exp_q[i].res, exp_q[i].tag);
         end
      end
      clear_logs();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      rst   = 1'b1;
      flush = 1'b0;
      bus.out_ready = 1'b0;
      set_in(1'b0, '0, '0, 2'b00, '0);
      @(posedge clk);
      #1;
      test_reset();
      test_ops();
      test_back_to_back();
      test_backpressure();
      test_bubble();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised, fully pipelined integer multiply unit for the RV32M/RV64M execute stage. Accepts one multiply per cycle under a valid/ready handshake and carries a destination tag alongside each operation. Supports downstream back-pressure with bubble collapsing and a pipeline flush for branch mispredicts and traps. Returns the low or high half of the product selected by `mulctl`.

## Interface
- `W`, 32: operand and result width. Legal values are 32 and 64.
- `L`, 4: pipeline depth in cycles, accept to `out_valid`. `L` must be at least 1.
- `TW`, 5: width of the tag field, which carries the rd index.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous kill of all in-flight operations.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept this cycle.
- `a`  in  W  multiplicand (rs1).
- `b`  in  W  multiplier (rs2).
- `mulctl`  in  2  operation select: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu.
- `in_tag`  in  TW  tag carried through the pipeline unchanged.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result this cycle.
- `mulres`  out  W  result.
- `out_tag`  out  TW  tag of the result.

## Operation
- **Transfer rule.** An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **Operand extension.** Each operand is extended to W+1 bits:
  - `a` is sign-extended when `mulctl` is 00, 01 or 10, and zero-extended when it is 11.
  - `b` is sign-extended when `mulctl` is 00 or 01, and zero-extended when it is 10 or 11.
- **Product and result select.** The full product is 2W bits. `mulres` is `product[W-1:0]` for `mulctl` 00, and `product[2W-1:W]` for all other values.
- **Stage registers.** The pipeline has L stages, 0 to L-1. Each stage has a valid bit v[k] plus data, tag and result-select bits.
  - The result-select bit travels with its operation. A different `mulctl` on a later operation never affects an earlier one.
- **Output stage.** Stage L-1 drives the outputs directly: `out_valid = v[L-1]`.
- **Advance rule.**
  - Stage L-1 empties when `out_ready` is high.
  - Stage k advances into k+1 if stage k+1 is empty or stage k+1 advances in the same cycle.
  - Bubbles collapse: a stalled output does not block earlier stages that have empty stages ahead of them.
- **Ready.** `in_ready` is `!v[0] || stage0_advances`. It is combinational and never depends on `in_valid`.
- **Stall hold.** While a stage holds, its data and tag stay unchanged. `mulres` and `out_tag` stay stable while `out_valid && !out_ready`.
- **Flush.** When `flush` is high, every v[k] clears at the next edge, and any input offered in that cycle is discarded.
  - Data registers may retain stale values.
  - `in_ready` is unaffected by `flush` in the flush cycle.
- **Reset priority.** `rst` overrides `flush`, and `flush` overrides accept.
- **Arithmetic.** The product may be split into partial products across stages in any way, provided the final value is bit-exact.

## Timing
- **Reset.** At reset, all v[k] are 0 and `out_valid` is 0. `mulres` and `out_tag` are 0. `in_ready` is 1 from the first cycle after reset.
- **Latency.** An operation accepted at edge n, with no back-pressure, has `out_valid` high after edge n+L.
- **Throughput.** One operation per cycle, sustained.
- **Capacity.** At most L operations are in flight. With `out_ready` held low, exactly L accepts occur before `in_ready` drops.
- **Simultaneous events.**
  - Output transfer and input transfer in the same cycle with a full pipe is legal and loses no data.
  - Flush and output transfer in the same cycle: the result is consumed and all other entries are killed.
- **Reset mid-operation.** All in-flight operations are lost. No `out_valid` appears until a new accept.
- **No combinational path** from `in_valid` or `a`/`b` to any output.

## Test plan
- **Per-operation results** (W=32, L=4, `out_ready`=1). Each result appears exactly 4 cycles after accept:
  - mul of 7 and 0xFFFFFFFD gives 0xFFFFFFEB.
  - mulh of 0x80000000 and 0x80000000 gives 0x40000000.
  - mulhsu of 0xFFFFFFFF and 0xFFFFFFFF gives 0xFFFFFFFF.
  - mulhu of 0xFFFFFFFF and 0xFFFFFFFF gives 0xFFFFFFFE.
- **Back-to-back issue.** Issue 8 consecutive operations with tags 0–7 and mixed `mulctl`. Required: 8 consecutive `out_valid` cycles, tags in order 0–7, each result bit-exact against a reference model.
- **Back-pressure.** Hold `out_ready`=0 while issuing 6 operations. Required: exactly 4 accepted, then `in_ready`=0, with `mulres`/`out_tag` frozen. Raise `out_ready`: results drain in order with no loss or duplication, and the remaining 2 operations are accepted.
- **Bubble collapse.** Issue operations with gaps (valid pattern 1,0,1,0) while `out_ready` is low for 2 cycles. Required: the gaps compress and `in_ready` stays 1 until 4 operations are held.
- **Flush.** Flush 2 cycles after 3 accepts, with `in_valid`=1 in the flush cycle. Required: no `out_valid` for any killed operation. The next accepted operation emerges after L cycles with the correct tag.
- **Reset.** Assert `rst` mid-stream with the pipe full and `out_ready`=0. Required: `out_valid`=0, `mulres`=0 and `out_tag`=0 the next cycle. `in_ready`=1 after release.
